// File: rtl/systolic_matmul_core.sv
// N x N output-stationary systolic matrix multiplier: captures A/B on a handshake,
// skews them through a MAC grid for 3N-2 steps, then holds C until the consumer takes it.
module systolic_matmul_core #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 2*DATA_W + $clog2(N),
  parameter int SIGNED = 0
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic [N*N*DATA_W-1:0]  i_a,
  input  logic [N*N*DATA_W-1:0]  i_b,
  input  logic                   i_validInput,
  output logic                   o_readyInput,
  output logic [N*N*ACC_W-1:0]   o_c,
  output logic                   o_validResult,
  input  logic                   i_readyResult,
  output logic                   o_busy
);
  localparam int LAST = 3*N - 2;
  localparam int TW   = $clog2(3*N);
  localparam int PW   = (ACC_W > 2*DATA_W) ? ACC_W : 2*DATA_W;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
  typedef logic [DATA_W-1:0] opnd_t;
  typedef logic [ACC_W-1:0]  acc_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        t_q, t_d;
  logic                 valid_q, valid_d;
  logic [N*N*ACC_W-1:0] c_q, c_d;
  opnd_t                a_q [N][N], a_d [N][N];
  opnd_t                b_q [N][N], b_d [N][N];
  opnd_t                ah_q [N][N], ah_d [N][N];
  opnd_t                bv_q [N][N], bv_d [N][N];
  opnd_t                a_in [N][N], b_in [N][N];
  acc_t                 acc_q [N][N], acc_d [N][N];

  // Operands are extended to a width covering both the full product and the
  // accumulator so the product is exact modulo 2^ACC_W in either signedness.
  function automatic acc_t mul_ext(input opnd_t x, input opnd_t y);
    logic [PW-1:0] ex, ey, p;
    if (SIGNED != 0) begin
      ex = PW'($signed(x));
      ey = PW'($signed(y));
    end else begin
      ex = PW'(x);
      ey = PW'(y);
    end
    p = ex * ey;
    return p[ACC_W-1:0];
  endfunction

  // Edge feeds: row i of A and column j of B enter delayed by i and j steps.
  always_comb begin
    a_in = '{default: '0};
    b_in = '{default: '0};
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        if (int'(t_q) == i + k) a_in[i][0] = a_q[i][k];
        if (int'(t_q) == i + k) b_in[0][i] = b_q[k][i];
      end
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 1; j < N; j++) begin
        a_in[i][j] = ah_q[i][j-1];
        b_in[j][i] = bv_q[j-1][i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    valid_d = valid_q;
    c_d     = c_q;
    a_d     = a_q;
    b_d     = b_q;
    ah_d    = ah_q;
    bv_d    = bv_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (i_validInput) begin
          for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
              a_d[i][j] = i_a[(i*N+j)*DATA_W +: DATA_W];
              b_d[i][j] = i_b[(i*N+j)*DATA_W +: DATA_W];
            end
          end
          acc_d   = '{default: '0};
          ah_d    = '{default: '0};
          bv_d    = '{default: '0};
          t_d     = '0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            acc_d[i][j] = acc_q[i][j] + mul_ext(a_in[i][j], b_in[i][j]);
          end
        end
        ah_d = a_in;
        bv_d = b_in;
        // The step after the last MAC only publishes; its feeds are all zero.
        if (t_q == TW'(LAST)) begin
          for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
              c_d[(i*N+j)*ACC_W +: ACC_W] = acc_q[i][j];
            end
          end
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      DONE: begin
        if (i_readyResult) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q <= IDLE;
      t_q     <= '0;
      valid_q <= 1'b0;
      c_q     <= '0;
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
      ah_q    <= '{default: '0};
      bv_q    <= '{default: '0};
      acc_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      valid_q <= valid_d;
      c_q     <= c_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ah_q    <= ah_d;
      bv_q    <= bv_d;
      acc_q   <= acc_d;
    end
  end

  assign o_readyInput  = (state_q == IDLE);
  assign o_busy        = (state_q != IDLE);
  assign o_validResult = valid_q;
  assign o_c           = c_q;
endmodule

// File: doc/systolic_matmul_core.md
Name: systolic_matmul_core

Overview:
Parametrised N x N output-stationary systolic matrix multiplier. Computes C = A x B for square matrices.
- Captures A and B on a valid/ready handshake.
- Skews rows of A and columns of B into an N x N multiply-accumulate PE grid.
- Presents C on a valid/ready result handshake.
- Next-generation top for the matrix-multiply datapath: generalises the fixed 4x4/8-bit input-capture top in size, element width, signedness and accumulator width.

Parameters:
N, 4, matrix dimension (N >= 2).
DATA_W, 8, element width of A and B.
ACC_W, 2*DATA_W+$clog2(N), width of each C element and PE accumulator.
SIGNED, 0, 0 = unsigned operands, 1 = two's-complement operands and result.

Ports:
i_clk  in  1  clock, rising edge.
i_arst  in  1  reset, asynchronous, active-high.
i_a  in  N*N*DATA_W  matrix A, packed [row][col][DATA_W], row 0/col 0 at LSBs.
i_b  in  N*N*DATA_W  matrix B, same packing.
i_validInput  in  1  A/B valid.
o_readyInput  out  1  core can accept A/B.
o_c  out  N*N*ACC_W  result C, packed [row][col][ACC_W].
o_validResult  out  1  o_c holds a completed result.
i_readyResult  in  1  consumer accepts result.
o_busy  out  1  state != IDLE.

Behaviour:
Reset: i_arst asynchronous, active-high; clock i_clk. On reset:
- o_c = 0, o_validResult = 0, o_busy = 0, o_readyInput = 1.
- Captured A/B registers, PE accumulators and skew pipelines cleared.
- FSM = IDLE.
- Reset mid-COMPUTE or mid-DONE aborts the operation; no result is produced.

FSM states: IDLE, COMPUTE, DONE.
- IDLE: o_readyInput = 1. Accept edge = rising edge with i_validInput && o_readyInput. On that edge: capture i_a/i_b, clear all accumulators, step counter t = 0, go to COMPUTE. i_validInput in any other state is ignored; inputs are not queued.
- COMPUTE: o_readyInput = 0.
  - On each edge, row i of A enters column 0 delayed by i cycles; column j of B enters row 0 delayed by j cycles. Operands shift one PE right/down per cycle.
  - On step t, PE(i,j) adds a[i][k]*b[k][j] for k = t-i-j when 0 <= k < N, else adds 0.
  - Steps t = 0..3N-3 (3N-2 cycles). After step 3N-3: copy accumulators to o_c, set o_validResult = 1, go to DONE.
- DONE: o_c and o_validResult held stable while i_readyResult = 0. On an edge with i_readyResult = 1: o_validResult = 0, go to IDLE. o_c keeps its last value until the next result overwrites it.

Latency: accept edge = cycle 0; o_validResult rises at cycle 3N-1 (N=4: cycle 11). Minimum initiation interval is 3N+1 cycles with i_readyResult tied high (the accept after the release edge lands one cycle later).

Arithmetic:
- Products are 2*DATA_W, signed or unsigned per SIGNED, sign/zero-extended to ACC_W.
- Accumulation is modulo 2^ACC_W (wraps, no saturation, no overflow flag).
- With the default ACC_W no overflow is possible.

Boundaries:
- i_readyResult high in the cycle o_validResult rises: result handed off at the next edge (one cycle valid).
- i_validInput held high through DONE: not accepted until IDLE is re-entered, one cycle after the release edge.
- i_a/i_b changing during COMPUTE has no effect.

Test Plan:
1. N=4, DATA_W=8, A = identity, B[i][j] = 4i+j, pulse valid at cycle 0, i_readyResult=1 -> o_validResult high at cycle 11 only, C[i][j] = 4i+j, o_busy high cycles 1..11.
2. A = B = all 255, SIGNED=0, default ACC_W=18 -> every C element = 260100. Same stimulus with ACC_W=16 -> every C element = 63492 (wrap).
3. SIGNED=1, A = B = all 0x80 -> every C element = 65536; A all 0xFF (-1), B all 0x02 -> every C element = -8 (0x3FFF8 at ACC_W=18).
4. Backpressure: i_readyResult=0 for 20 cycles after valid, new i_validInput asserted meanwhile -> o_c stable, o_readyInput=0, second input not taken. Raise ready -> valid drops next edge; second input accepted at the following edge.
5. Assert i_arst at COMPUTE step 5, release -> all outputs 0, o_readyInput=1, no o_validResult pulse. Next operation yields a correct result with no residue from the aborted one.
6. N=2, DATA_W=4, back-to-back with random matrices, i_validInput and i_readyResult tied high -> results every 7 cycles (first at cycle 5), each matching a reference model.
